// File: rtl/axil_led_gpio_slave.sv
// AXI4-Lite register slave: LED/GPIO bank, scratch, ID and heartbeat.
// Drives gpio_led_out from LED_OUT or a heartbeat-derived blink pattern.
module axil_led_gpio_slave #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] ID_VALUE  = 32'h1900_C0DE,
  parameter logic [3:0]  LED_RESET = 4'b0000,
  parameter int          BLINK_BIT = 26
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [3:0]        gpio_led_out
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [ADDR_W-3:0] N_REGS = (ADDR_W-2)'(5);

  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-3:0] aw_idx;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              rvalid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  logic [3:0]        led_reg;
  logic [31:0]       scratch;
  logic              blink;
  logic [31:0]       hb;
  logic [3:0]        led_q;

  logic              wr_go;
  logic              wr_ok;
  logic              ar_ok;
  logic [31:0]       rd_word;
  logic [1:0]        rd_resp;
  logic              unused_ok;

  assign unused_ok = ^{s_axil_araddr[1:0], s_axil_awaddr[1:0]};

  // Readies are forced low while reset is held.
  assign s_axil_awready = !rst && !aw_held && !bvalid;
  assign s_axil_wready  = !rst && !w_held && !bvalid;
  assign s_axil_arready = !rst && !rvalid;

  assign s_axil_bvalid = bvalid;
  assign s_axil_bresp  = bresp;
  assign s_axil_rvalid = rvalid;
  assign s_axil_rdata  = rdata;
  assign s_axil_rresp  = rresp;
  assign gpio_led_out  = led_q;

  assign wr_go = aw_held && w_held && !bvalid;
  assign wr_ok = aw_idx < N_REGS;
  assign ar_ok = s_axil_araddr[ADDR_W-1:2] < N_REGS;

  always_comb begin
    rd_word = '0;
    rd_resp = OKAY;
    if (!ar_ok) begin
      rd_resp = SLVERR;
    end else begin
      unique case (s_axil_araddr[4:2])
        3'd0:    rd_word = ID_VALUE;
        3'd1:    rd_word = {28'd0, led_reg};
        3'd2:    rd_word = scratch;
        3'd3:    rd_word = hb;
        3'd4:    rd_word = {31'd0, blink};
        default: rd_resp = SLVERR;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      if (s_axil_awvalid && s_axil_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axil_awaddr[ADDR_W-1:2];
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_held  <= 1'b1;
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      if (wr_go) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? OKAY : SLVERR;
      end
      if (bvalid && s_axil_bready) begin
        bvalid  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      led_reg <= LED_RESET;
      scratch <= '0;
      blink   <= 1'b0;
    end else if (wr_go && wr_ok) begin
      if (aw_idx[2:0] == 3'd1 && wstrb_q[0])
        led_reg <= wdata_q[3:0];
      if (aw_idx[2:0] == 3'd2) begin
        for (int i = 0; i < 4; i++)
          if (wstrb_q[i])
            scratch[8*i +: 8] <= wdata_q[8*i +: 8];
      end
      if (aw_idx[2:0] == 3'd4 && wstrb_q[0])
        blink <= wdata_q[0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= OKAY;
    end else if (s_axil_arvalid && s_axil_arready) begin
      rvalid <= 1'b1;
      rdata  <= rd_word;
      rresp  <= rd_resp;
    end else if (rvalid && s_axil_rready) begin
      rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hb    <= '0;
      led_q <= LED_RESET;
    end else begin
      hb    <= hb + 32'd1;
      led_q <= blink ? ({4{hb[BLINK_BIT]}} ^ 4'b0101) : led_reg;
    end
  end

endmodule

// File: tb/tb_axil_led_gpio_slave.sv
// Randomized self-checking bench for axil_led_gpio_slave against
// a register-map reference model (blink bit set to 2).
module tb_axil_led_gpio_slave;

  localparam logic [31:0] ID = 32'h1900_C0DE;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [11:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  gpio;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]  m_led;
  logic [31:0] m_scratch;
  logic        m_ctrl;
  logic [31:0] hbm;

  axil_led_gpio_slave #(
    .ADDR_W(12), .ID_VALUE(ID),
    .LED_RESET(4'b0000), .BLINK_BIT(2)
  ) dut (
    .clk_in(clk_in), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
    .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .gpio_led_out(gpio)
  );

  always #5 clk_in = ~clk_in;

  // Cycles elapsed since the last reset edge: the heartbeat value.
  always @(posedge clk_in) begin
    if (rst) hbm <= 32'd0;
    else     hbm <= hbm + 32'd1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    m_led = 4'b0000;
    m_scratch = 32'd0;
    m_ctrl = 1'b0;
  endtask

  function automatic logic [3:0] exp_led();
    logic [31:0] p;
    p = hbm - 32'd1;
    return m_ctrl ? ({4{p[2]}} ^ 4'b0101) : m_led;
  endfunction

  function automatic logic [1:0] model_write(input logic [11:0] a,
                                            input logic [31:0] d,
                                            input logic [3:0] s);
    int off;
    off = int'(a) & 32'hFFC;
    if (off >= 20) return 2'b10;
    if (off == 4 && s[0]) m_led = d[3:0];
    if (off == 8)
      for (int i = 0; i < 4; i++)
        if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
    if (off == 16 && s[0]) m_ctrl = d[0];
    return 2'b00;
  endfunction

  task automatic model_read(input logic [11:0] a,
                            input logic [31:0] hbv,
                            output logic [31:0] d,
                            output logic [1:0] r);
    int off;
    off = int'(a) & 32'hFFC;
    d = 32'd0;
    r = 2'b00;
    case (off)
      0:  d = ID;
      4:  d = {28'd0, m_led};
      8:  d = m_scratch;
      12: d = hbv;
      16: d = {31'd0, m_ctrl};
      default: r = 2'b10;
    endcase
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_at,
                          input int w_at, input int stall,
                          output logic [1:0] resp, output int lat,
                          output logic [3:0] led_at_b);
    bit awd, wd;
    int t;
    awd = 0; wd = 0; t = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(awd && wd) && t < 40) begin
      awvalid = !awd && t >= aw_at;
      wvalid = !wd && t >= w_at;
      if (awvalid && awready) awd = 1;
      if (wvalid && wready) wd = 1;
      tick();
      t++;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    if (!(awd && wd)) chk("wr_hs_timeout", 0, 1);
    lat = 0;
    while (!bvalid && lat < 20) begin
      tick();
      lat++;
    end
    resp = bresp;
    led_at_b = gpio;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("aw_stall", awready, 0);
      chk("w_stall", wready, 0);
      chk("bresp_hold", {bvalid, bresp}, {1'b1, resp});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_drop", bvalid, 0);
  endtask

  task automatic do_read(input logic [11:0] a,
                         output logic [31:0] d, output logic [1:0] r,
                         output int lat, output logic [31:0] hbv);
    bit done;
    int t;
    done = 0; t = 0; hbv = 32'd0;
    araddr = a;
    arvalid = 1'b1;
    while (!done && t < 40) begin
      if (arready) begin
        done = 1;
        hbv = hbm;
      end
      tick();
      t++;
    end
    arvalid = 1'b0;
    if (!done) chk("ar_timeout", 0, 1);
    lat = 1;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
    end
    d = rdata;
    r = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("r_drop", rvalid, 0);
  endtask

  task automatic wr_chk(input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int aw_at,
                        input int w_at, input int stall);
    logic [1:0] resp, er;
    logic [3:0] lb;
    int lat;
    er = model_write(a, d, s);
    do_write(a, d, s, aw_at, w_at, stall, resp, lat, lb);
    chk("bresp", resp, er);
    chk("b_lat", lat, 1);
  endtask

  task automatic rd_chk(input logic [11:0] a);
    logic [31:0] d, ed, hbv;
    logic [1:0] r, er;
    int lat;
    do_read(a, d, r, lat, hbv);
    model_read(a, hbv, ed, er);
    chk("rdata", d, ed);
    chk("rresp", r, er);
    chk("r_lat", lat, 1);
  endtask

  initial begin
    logic [31:0] d, h1, h2;
    logic [1:0]  r;
    logic [3:0]  lb, prev;
    int lat, changes;

    model_reset();
    repeat (3) tick();
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_valids", {bvalid, rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_gpio", gpio, 0);
    rst = 1'b0;
    tick();

    rd_chk(12'h000);
    chk("gpio_init", gpio, 4'b0000);

    // W leads AW by three cycles.
    void'(model_write(12'h004, 32'hA, 4'h1));
    do_write(12'h004, 32'hA, 4'h1, 3, 0, 0, r, lat, lb);
    chk("led_bresp", r, 2'b00);
    chk("led_b_lat", lat, 1);
    chk("led_at_commit", lb, 4'b0000);
    chk("led_after", gpio, 4'b1010);

    wr_chk(12'h008, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    wr_chk(12'h008, 32'h1122_3344, 4'h5, 1, 0, 5);
    do_read(12'h008, d, r, lat, h1);
    chk("scratch_strb", d, 32'hFF22_FF44);

    rd_chk(12'h020);
    wr_chk(12'h018, 32'hDEAD_BEEF, 4'hF, 0, 2, 1);
    rd_chk(12'h004);
    rd_chk(12'h008);
    rd_chk(12'h010);

    wr_chk(12'h010, 32'h1, 4'h1, 0, 0, 0);
    prev = gpio;
    changes = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("blink", gpio, exp_led());
      if (gpio != prev) changes++;
      prev = gpio;
    end
    chk("blink_toggles", changes, 4);

    do_read(12'h00C, h1, r, lat, d);
    chk("hb_abs", h1, d);
    repeat (8) tick();
    do_read(12'h00C, h2, r, lat, d);
    chk("hb_diff", h2 - h1, 10);
    wr_chk(12'h010, 32'h0, 4'h1, 0, 0, 0);

    // Reset with both a write response and read data pending.
    awaddr = 12'h004; wdata = 32'h5; wstrb = 4'h1;
    araddr = 12'h008;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    chk("pend_valids", {bvalid, rvalid}, 2'b11);
    tick();
    chk("pend_led", gpio, 4'h5);
    rst = 1'b1;
    tick();
    chk("mid_rst_valids", {bvalid, rvalid}, 2'b00);
    chk("mid_rst_gpio", gpio, 4'h0);
    rst = 1'b0;
    model_reset();
    tick();
    chk("post_rst_valids", {bvalid, rvalid}, 2'b00);
    rd_chk(12'h004);
    rd_chk(12'h008);
    wr_chk(12'h004, 32'h3, 4'h1, 0, 0, 0);
    rd_chk(12'h004);

    for (int n = 0; n < 80; n++) begin
      logic [11:0] a;
      if ($urandom_range(0, 7) == 0)
        a = 12'($urandom) & 12'hFFC;
      else
        a = 12'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        wr_chk(a, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3));
      else
        rd_chk(a);
      chk("gpio_rand", gpio, exp_led());
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
